// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter that sits on the CPU data-memory bus.
// Stores to TXDATA push bytes into a small FIFO. The bytes are sent LSB first as 8N1 frames
// on tx. Loads return status or the baud divisor.
//
// Register window (word offsets from BASE_ADDR; addr[1:0] ignored):
//   +0 TXDATA  W: push data[7:0]            R: 0
//   +4 STATUS  R: {count[15:8], par_en[4], overflow[3], empty[2], full[1], busy[0]}
//              W: any value clears overflow
//   +8 DIV     R/W: data[15:0], clk cycles per bit (0 behaves as 1)
//   +12 and all addresses outside the window read 0 and ignore writes.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   addr  byte address from the CPU data port
//   data  store data
//   we    store strobe
//   out   load data, combinational from addr
//   tx    serial line, idle high
//
// Optional build macro UART_TX_PARITY_EN: inserts an even-parity bit before the stop bit
// (8E1 frame) and sets STATUS bit4.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [15:0] DIV_RESET  = 16'd16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] data,
   input  logic        we,
   output logic [31:0] out,
   output logic        tx
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

   state_e            state;
   logic [7:0]        shift;
   logic [2:0]        bit_idx;
   logic [15:0]       cnt;
   logic [15:0]       period;
   logic [15:0]       div;
   logic              overflow;
`ifdef UART_TX_PARITY_EN
   logic              par;
`endif

   logic [7:0]        mem [FIFO_DEPTH];
   logic [PtrW-1:0]   wr_ptr, rd_ptr;
   logic [CntW-1:0]   count;

   // Register decode
   logic hit, sel_txd, sel_stat, sel_div;
   assign hit      = addr[31:4] == BASE_ADDR[31:4];
   assign sel_txd  = hit && (addr[3:2] == 2'd0);
   assign sel_stat = hit && (addr[3:2] == 2'd1);
   assign sel_div  = hit && (addr[3:2] == 2'd2);

   logic unused_bits;
   assign unused_bits = ^{addr[1:0], data[31:16]};

   logic full, empty, bit_end, pop, push, ovf_set, wr_txd;
   logic [7:0]  head;
   logic [15:0] p_next;

   assign full    = count == CntW'(FIFO_DEPTH);
   assign empty   = count == '0;
   assign bit_end = cnt == (period - 16'd1);
   assign head    = mem[rd_ptr];
   assign p_next  = (div == 16'd0) ? 16'd1 : div;

   // The FSM pops from IDLE, or at the end of a stop bit so frames run back to back.
   assign pop     = !empty && ((state == StIdle) || ((state == StStop) && bit_end));
   assign wr_txd  = we && sel_txd;
   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   assign push    = wr_txd && (!full || pop);
   assign ovf_set = wr_txd && full && !pop;

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PtrW'(1);
         if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
         count <= count + CntW'(push) - CntW'(pop);
      end
   end

   // FIFO storage needs no reset; count gates every read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data[7:0];
   end

   // Divisor and sticky overflow
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div      <= DIV_RESET;
         overflow <= 1'b0;
      end else begin
         if (we && sel_div) div <= data[15:0];
         if (we && sel_stat)  overflow <= 1'b0;
         else if (ovf_set)    overflow <= 1'b1;
      end
   end

   // Transmit FSM; tx is registered so it changes only on clock edges (or reset).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= StIdle;
         tx      <= 1'b1;
         shift   <= 8'd0;
         bit_idx <= 3'd0;
         cnt     <= 16'd0;
         period  <= 16'd1;
`ifdef UART_TX_PARITY_EN
         par     <= 1'b0;
`endif
      end else begin
         case (state)
            StIdle: begin
               if (pop) begin
                  state  <= StStart;
                  tx     <= 1'b0;
                  shift  <= head;
                  period <= p_next;
                  cnt    <= 16'd0;
`ifdef UART_TX_PARITY_EN
                  par    <= ^head;
`endif
               end
            end
            StStart: begin
               if (bit_end) begin
                  state   <= StData;
                  tx      <= shift[0];
                  cnt     <= 16'd0;
                  bit_idx <= 3'd0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            StData: begin
               if (bit_end) begin
                  cnt <= 16'd0;
                  if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state <= StParity;
                     tx    <= par;
`else
                     state <= StStop;
                     tx    <= 1'b1;
`endif
                  end else begin
                     shift   <= {1'b0, shift[7:1]};
                     tx      <= shift[1];
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
               if (bit_end) begin
                  state <= StStop;
                  tx    <= 1'b1;
                  cnt   <= 16'd0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
`endif
            StStop: begin
               if (bit_end) begin
                  if (pop) begin
                     state  <= StStart;
                     tx     <= 1'b0;
                     shift  <= head;
                     period <= p_next;
                     cnt    <= 16'd0;
`ifdef UART_TX_PARITY_EN
                     par    <= ^head;
`endif
                  end else begin
                     state <= StIdle;
                     tx    <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: begin
               state <= StIdle;
               tx    <= 1'b1;
            end
         endcase
      end
   end

   // Load data
   logic [31:0] status;
   always_comb begin
      status       = 32'd0;
      status[0]    = state != StIdle;
      status[1]    = full;
      status[2]    = empty;
      status[3]    = overflow;
`ifdef UART_TX_PARITY_EN
      status[4]    = 1'b1;
`endif
      status[15:8] = 8'(count);
   end

   always_comb begin
      out = 32'd0;
      if (sel_stat)     out = status;
      else if (sel_div) out = {16'd0, div};
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a queue-based model of the byte FIFO and of the expected tx
// waveform, checked every cycle, plus directed reads with hand-computed values.
module tb_mmio_uart_tx;

   localparam logic [31:0] Base  = 32'h0000_1000;
   localparam int          Depth = 4;
`ifdef UART_TX_PARITY_EN
   localparam int          FrameBits = 11;
   localparam logic [31:0] StPar     = 32'h10;
   logic [31:0] a5_bits[$] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
   localparam int          FrameBits = 10;
   localparam logic [31:0] StPar     = 32'h0;
   logic [31:0] a5_bits[$] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] data = 32'd0;
   logic        we = 1'b0;
   logic [31:0] out;
   logic        tx;

   mmio_uart_tx #(
      .BASE_ADDR (Base),
      .FIFO_DEPTH(Depth),
      .DIV_RESET (16'd16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .addr(addr),
      .data(data),
      .we  (we),
      .out (out),
      .tx  (tx)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   logic [7:0]  m_fifo[$];
   logic        m_wave[$];   // expected tx, one entry per cycle, front = current cycle
   logic [15:0] m_div;
   logic        m_ovf;

   function automatic void build_frame(input logic [7:0] b);
      int   p;
      logic bits[$];
      p = (m_div == 16'd0) ? 1 : int'(m_div);
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
      bits.push_back(^b);
`endif
      bits.push_back(1'b1);
      foreach (bits[i]) for (int k = 0; k < p; k++) m_wave.push_back(bits[i]);
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_fifo.delete();
         m_wave.delete();
         m_div = 16'd16;
         m_ovf = 1'b0;
      end else begin
         if (m_wave.size() != 0) void'(m_wave.pop_front());
         if (m_wave.size() == 0 && m_fifo.size() != 0) build_frame(m_fifo.pop_front());
         if (we && ((addr >> 4) == (Base >> 4))) begin
            case (addr[3:2])
               2'd0: if (m_fifo.size() < Depth) m_fifo.push_back(data[7:0]);
                     else m_ovf = 1'b1;
               2'd1: m_ovf = 1'b0;
               2'd2: m_div = data[15:0];
               default: ;
            endcase
         end
      end
   end

   function automatic logic model_tx();
      return (m_wave.size() != 0) ? m_wave[0] : 1'b1;
   endfunction

   function automatic logic [31:0] model_out(input logic [31:0] a);
      logic [31:0] r;
      r = 32'd0;
      if ((a >> 4) == (Base >> 4)) begin
         case (a[3:2])
            2'd1: begin
               r[0]    = m_wave.size() != 0;
               r[1]    = m_fifo.size() == Depth;
               r[2]    = m_fifo.size() == 0;
               r[3]    = m_ovf;
               r       = r | StPar;
               r[15:8] = 8'(m_fifo.size());
            end
            2'd2: r[15:0] = m_div;
            default: ;
         endcase
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_tx", {31'd0, tx}, {31'd0, model_tx()});
         chk("model_out", out, model_out(addr));
      end
   end

   // ---------------- stimulus (tasks entered 1ns after a rising edge) ----------------
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr = a;
      data = d;
      we   = 1'b1;
      @(posedge clk);
      #1 we = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
      addr = a;
      #1 chk(name, out, exp);
   endtask

   initial begin
      tick(3);
      rst    = 1'b1;
      chk_en = 1'b1;

      // Reset state
      rd("reset_status", Base + 32'd4, 32'h0000_0004 | StPar);
      rd("reset_div", Base + 32'd8, 32'h0000_0010);
      chk("reset_tx", {31'd0, tx}, 32'd1);
      tick(1);

      // Single frame, DIV=4, byte A5
      wr(Base + 32'd8, 32'd4);
      wr(Base, 32'h0000_00A5);
      for (int k = 0; k < FrameBits * 4; k++) begin
         tick(1);
         chk("a5_bit", {31'd0, tx}, a5_bits[k / 4]);
      end
      rd("a5_busy_hi", Base + 32'd4, 32'h0000_0005 | StPar);
      tick(1);
      rd("a5_busy_lo", Base + 32'd4, 32'h0000_0004 | StPar);
      tick(1);

      // Back-to-back burst, DIV=2
      wr(Base + 32'd8, 32'd2);
      for (int i = 1; i <= 5; i++) wr(Base, i);
      rd("burst_full", Base + 32'd4, 32'h0000_0403 | StPar);
      tick(5 * FrameBits * 2 - 4);
      rd("burst_busy_hi", Base + 32'd4, 32'h0000_0005 | StPar);
      tick(1);
      rd("burst_busy_lo", Base + 32'd4, 32'h0000_0004 | StPar);
      tick(1);

      // Overflow, DIV=8
      wr(Base + 32'd8, 32'd8);
      for (int i = 0; i < 6; i++) wr(Base, 32'h10 + i);
      rd("ovf_set", Base + 32'd4, 32'h0000_040B | StPar);
      wr(Base + 32'd4, 32'hDEAD_BEEF);
      rd("ovf_clr", Base + 32'd4, 32'h0000_0403 | StPar);
      tick(5 * FrameBits * 8 + 20);
      rd("ovf_drained", Base + 32'd4, 32'h0000_0004 | StPar);
      tick(1);

      // DIV=0 acts as one cycle per bit; a DIV write mid-frame applies to the next frame
      wr(Base + 32'd8, 32'd0);
      wr(Base, 32'h3C);
      wr(Base + 32'd8, 32'd3);
      wr(Base, 32'hC3);
      tick(FrameBits * 4 + 10);
      rd("div_readback", Base + 32'd8, 32'h0000_0003);
      tick(1);

      // Asynchronous reset mid-DATA with three bytes queued
      wr(Base + 32'd8, 32'd4);
      wr(Base, 32'hFF);
      wr(Base, 32'h01);
      wr(Base, 32'h02);
      wr(Base, 32'h03);
      tick(6);
      #1 rst = 1'b0;
      #1 chk("rst_tx", {31'd0, tx}, 32'd1);
      rd("rst_status", Base + 32'd4, 32'h0000_0004 | StPar);
      rd("rst_div", Base + 32'd8, 32'h0000_0010);
      tick(1);
      rst = 1'b1;
      tick(60);
      chk("rst_quiet_tx", {31'd0, tx}, 32'd1);
      rd("rst_quiet_status", Base + 32'd4, 32'h0000_0004 | StPar);
      tick(1);

      // Unmapped offsets and foreign addresses
      rd("offset_c", Base + 32'd12, 32'd0);
      tick(1);
      rd("foreign", 32'h0000_2000, 32'd0);
      tick(1);
      wr(32'h0000_2000, 32'hFF);
      wr(Base + 32'd12, 32'h55);
      rd("foreign_status", Base + 32'd5, 32'h0000_0004 | StPar);
      tick(30);
      chk("foreign_tx", {31'd0, tx}, 32'd1);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
